// File: rtl/memtrace_lane_serializer_if.sv
// Bus bundle between the memory-trace blackbox, the lane serializer and the
// downstream request consumer. master = serializer side, slave = environment side.
interface memtrace_lane_serializer_if #(
  parameter int unsigned NUM_LANES = 4
);
  localparam int unsigned LANE_ID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [63:0]             trace_read_cycle;
  logic                    trace_read_ready;
  logic [NUM_LANES-1:0]    trace_read_valid;
  logic [64*NUM_LANES-1:0] trace_read_address;
  logic [NUM_LANES-1:0]    trace_read_is_store;
  logic [8*NUM_LANES-1:0]  trace_read_size;
  logic [64*NUM_LANES-1:0] trace_read_data;
  logic                    trace_read_finished;

  logic                    req_valid;
  logic                    req_ready;
  logic [LANE_ID_W-1:0]    req_lane;
  logic [63:0]             req_address;
  logic                    req_is_store;
  logic [7:0]              req_size;
  logic [63:0]             req_data;

  logic                    done;

  modport master (
    output trace_read_cycle, trace_read_ready,
    input  trace_read_valid, trace_read_address, trace_read_is_store,
    input  trace_read_size, trace_read_data, trace_read_finished,
    output req_valid, req_lane, req_address, req_is_store, req_size, req_data,
    input  req_ready,
    output done
  );

  modport slave (
    input  trace_read_cycle, trace_read_ready,
    output trace_read_valid, trace_read_address, trace_read_is_store,
    output trace_read_size, trace_read_data, trace_read_finished,
    input  req_valid, req_lane, req_address, req_is_store, req_size, req_data,
    output req_ready,
    input  done
  );
endinterface

// File: rtl/memtrace_lane_serializer.sv
// Captures one multi-lane trace line per fetch and issues one request per valid
// lane, lowest first. Optional alignment monitor enabled by MEMTRACE_ALIGN_CHECK_EN.
module memtrace_lane_serializer #(
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  memtrace_lane_serializer_if.master bus
`ifdef MEMTRACE_ALIGN_CHECK_EN
  ,
  output logic                       req_misaligned,
  output logic [31:0]                misaligned_count
`endif
);

  localparam int unsigned LANE_ID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               r_state;
  logic [63:0]          r_cycle;
  logic                 r_ready;
  logic                 r_req_valid;
  logic                 r_done;
  logic                 r_fin;
  logic [NUM_LANES-1:0] r_pending;
  logic [63:0]          r_addr  [NUM_LANES];
  logic [63:0]          r_data  [NUM_LANES];
  logic [7:0]           r_size  [NUM_LANES];
  logic [NUM_LANES-1:0] r_store;

  logic [LANE_ID_W-1:0] w_sel;
  logic [NUM_LANES-1:0] w_onehot;
  logic [NUM_LANES-1:0] w_pending_clr;
  logic                 w_hs;

  // Lowest pending lane wins; scanning downward leaves the lowest index last.
  always_comb begin
    w_sel = '0;
    for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
      if (r_pending[i]) w_sel = LANE_ID_W'(i);
    end
  end

  assign w_onehot      = NUM_LANES'(1) << w_sel;
  assign w_pending_clr = r_pending & ~w_onehot;
  assign w_hs          = r_req_valid & bus.req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cycle     <= '0;
      r_ready     <= 1'b0;
      r_req_valid <= 1'b0;
      r_done      <= 1'b0;
      r_fin       <= 1'b0;
      r_pending   <= '0;
      r_store     <= '0;
      for (int g = 0; g < int'(NUM_LANES); g++) begin
        r_addr[g] <= '0;
        r_data[g] <= '0;
        r_size[g] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_ready <= 1'b1;
        end
        FETCH: begin
          r_ready <= 1'b0;
          r_cycle <= r_cycle + 64'd1;
          r_state <= LOAD;
        end
        LOAD: begin
          for (int g = 0; g < int'(NUM_LANES); g++) begin
            r_addr[g] <= bus.trace_read_address[64*g +: 64];
            r_data[g] <= bus.trace_read_data[64*g +: 64];
            r_size[g] <= bus.trace_read_size[8*g +: 8];
          end
          r_store   <= bus.trace_read_is_store;
          r_pending <= bus.trace_read_valid;
          if (|bus.trace_read_valid) begin
            r_fin       <= bus.trace_read_finished;
            r_req_valid <= 1'b1;
            r_state     <= DRAIN;
          end else if (bus.trace_read_finished) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_ready <= 1'b1;
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          if (w_hs) begin
            r_pending <= w_pending_clr;
            if (w_pending_clr == '0) begin
              r_req_valid <= 1'b0;
              if (r_fin) begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_ready <= 1'b1;
                r_state <= FETCH;
              end
            end
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.trace_read_cycle = r_cycle;
  assign bus.trace_read_ready = r_ready;
  assign bus.req_valid        = r_req_valid;
  assign bus.done             = r_done;

  // Payload is a pure mux of the captured line, so it cannot move while stalled.
  assign bus.req_lane     = w_sel;
  assign bus.req_address  = r_addr[w_sel];
  assign bus.req_is_store = r_store[w_sel];
  assign bus.req_size     = r_size[w_sel];
  assign bus.req_data     = r_data[w_sel];

`ifdef MEMTRACE_ALIGN_CHECK_EN
  logic [5:0]  w_mask;
  logic        w_misaligned;
  logic [31:0] r_mis_cnt;

  // Sizes of 64 bytes and above only look at the low six address bits.
  always_comb begin
    w_mask = '0;
    if (bus.req_size >= 8'd6) w_mask = 6'h3F;
    else                      w_mask = 6'((7'd1 << bus.req_size[2:0]) - 7'd1);
  end

  assign w_misaligned = r_req_valid & (|(bus.req_address[5:0] & w_mask));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mis_cnt <= '0;
    end else if (w_hs && w_misaligned && (r_mis_cnt != 32'hFFFF_FFFF)) begin
      r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign req_misaligned   = w_misaligned;
  assign misaligned_count = r_mis_cnt;
`endif

endmodule

// File: tb/tb_memtrace_lane_serializer.sv
// Self-checking bench for memtrace_lane_serializer: a blackbox model feeds a line
// table, a scoreboard queue holds the requests each fetched line must produce.
module tb_memtrace_lane_serializer;

  localparam int unsigned NL      = 4;
  localparam int          MAX_CYC = 400;

  typedef struct packed {
    logic [3:0]   valid;
    logic [3:0]   st;
    logic         fin;
    logic [255:0] addr;
    logic [31:0]  size;
    logic [255:0] data;
  } line_t;

  typedef struct packed {
    logic [1:0]  lane;
    logic [63:0] addr;
    logic        st;
    logic [7:0]  size;
    logic [63:0] data;
  } req_t;

  typedef struct {
    int first;
    int count;
    int stall;
    bit rnd;
    int exp_fetch;
    int exp_reqs;
  } scen_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memtrace_lane_serializer_if #(.NUM_LANES(NL)) bus ();

`ifdef MEMTRACE_ALIGN_CHECK_EN
  logic        req_misaligned;
  logic [31:0] misaligned_count;
`endif

  memtrace_lane_serializer #(.NUM_LANES(NL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef MEMTRACE_ALIGN_CHECK_EN
    ,
    .req_misaligned   (req_misaligned),
    .misaligned_count (misaligned_count)
`endif
  );

  int    checks = 0;
  int    errors = 0;
  line_t lines[12];
  scen_t sc[5];
  req_t  exp_q[$];
  int    bb_next, bb_end, fetches, nreq, cyc, last_fetch, first_fetch, stall_left;
  int    mis_model;
  logic [3:0] prev_valid;
  bit    rnd_mode, timing_chk, hold_chk;
  req_t  held;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic line_t mk(input logic [3:0] v, input logic fin,
                               input logic [63:0] a0, input logic [63:0] a1,
                               input logic [63:0] a2, input logic [63:0] a3,
                               input logic [7:0] sz);
    line_t l;
    logic [63:0] k;
    k       = 64'hC0FF_EE00_5A5A_0000;
    l.valid = v;
    l.fin   = fin;
    l.st    = 4'b0110;
    l.addr  = {a3, a2, a1, a0};
    l.size  = {4{sz}};
    l.data  = {a3 ^ k ^ 64'd3, a2 ^ k ^ 64'd2, a1 ^ k ^ 64'd1, a0 ^ k};
    return l;
  endfunction

  function automatic logic mis(input req_t r);
    logic [5:0] m;
    if (r.size >= 8'd6) m = 6'h3F;
    else                m = 6'((7'd1 << r.size[2:0]) - 7'd1);
    return |(r.addr[5:0] & m);
  endfunction

  function automatic req_t cur_req();
    req_t r;
    r = {bus.req_lane, bus.req_address, bus.req_is_store, bus.req_size, bus.req_data};
    return r;
  endfunction

  task automatic apply_line(input line_t l);
    bus.trace_read_valid    = l.valid;
    bus.trace_read_is_store = l.st;
    bus.trace_read_finished = l.fin;
    bus.trace_read_address  = l.addr;
    bus.trace_read_size     = l.size;
    bus.trace_read_data     = l.data;
  endtask

  // One clock: request-side scoreboard, then blackbox fetch model.
  task automatic step();
    bit    rdy;
    req_t  a;
    req_t  e;
    line_t l;
    @(negedge clock);
    cyc++;
    a = cur_req();
    if (hold_chk) begin
      chk("hold_valid", 160'(bus.req_valid), 160'(1'b1));
      chk("hold_payload", 160'(a), 160'(held));
    end
    if (bus.req_valid) begin
      if (rnd_mode)            rdy = ($urandom_range(2) != 0);
      else if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
      else                     rdy = 1'b1;
    end else begin
      rdy = 1'b1;
    end
    bus.req_ready = rdy;
    if (bus.req_valid && rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=%0h required=none", a);
      end else begin
        e = exp_q.pop_front();
        chk("req", 160'(a), 160'(e));
        nreq++;
`ifdef MEMTRACE_ALIGN_CHECK_EN
        chk("req_misaligned", 160'(req_misaligned), 160'(mis(e)));
        if (mis(e)) mis_model++;
`endif
      end
    end
    hold_chk = bus.req_valid && !rdy;
    held     = a;
    if (bus.trace_read_ready) begin
      chk("fetch_cycle", 160'(bus.trace_read_cycle), 160'(fetches));
      if (fetches == 0) first_fetch = cyc;
      else if (timing_chk)
        chk("line_cost", 160'(cyc - last_fetch), 160'(2 + $countones(prev_valid)));
      last_fetch = cyc;
      fetches++;
      if (bb_next < bb_end) l = lines[bb_next];
      else l = mk(4'b0000, 1'b1, '0, '0, '0, '0, 8'd0);
      bb_next++;
      apply_line(l);
      prev_valid = l.valid;
      for (int g = 0; g < 4; g++) begin
        if (l.valid[g]) begin
          e.lane = 2'(g);
          e.addr = l.addr[64*g +: 64];
          e.st   = l.st[g];
          e.size = l.size[8*g +: 8];
          e.data = l.data[64*g +: 64];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", 160'(bus.trace_read_ready), 160'(1'b0));
    chk("rst_cycle", 160'(bus.trace_read_cycle), 160'(64'd0));
    chk("rst_req_valid", 160'(bus.req_valid), 160'(1'b0));
    chk("rst_payload", 160'(cur_req()), 160'(0));
    chk("rst_done", 160'(bus.done), 160'(1'b0));
`ifdef MEMTRACE_ALIGN_CHECK_EN
    chk("rst_mis_count", 160'(misaligned_count), 160'(32'd0));
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b1;
    bus.req_ready = 1'b0;
    apply_line('0);
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clock);
  endtask

  task automatic setup(input scen_t s);
    bb_next    = s.first;
    bb_end     = s.first + s.count;
    stall_left = s.stall;
    rnd_mode   = s.rnd;
    timing_chk = !s.rnd && (s.stall == 0);
    exp_q.delete();
    fetches     = 0;
    nreq        = 0;
    cyc         = 0;
    first_fetch = 0;
    last_fetch  = 0;
    hold_chk    = 1'b0;
    prev_valid  = '0;
    mis_model   = 0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run_scen(input scen_t s);
    do_reset();
    setup(s);
    for (int i = 0; i < MAX_CYC; i++) begin
      step();
      if (bus.done) break;
    end
    chk("done", 160'(bus.done), 160'(1'b1));
    chk("first_fetch_cyc", 160'(first_fetch), 160'(2));
    chk("fetches", 160'(fetches), 160'(s.exp_fetch));
    chk("final_cycle", 160'(bus.trace_read_cycle), 160'(s.exp_fetch));
    chk("req_count", 160'(nreq), 160'(s.exp_reqs));
    chk("sb_empty", 160'(exp_q.size()), 160'(0));
    repeat (3) step();
    chk("done_sticky", 160'(bus.done), 160'(1'b1));
    chk("no_fetch_after_done", 160'(fetches), 160'(s.exp_fetch));
    chk("done_ready_low", 160'(bus.trace_read_ready), 160'(1'b0));
    chk("done_req_low", 160'(bus.req_valid), 160'(1'b0));
`ifdef MEMTRACE_ALIGN_CHECK_EN
    chk("mis_count", 160'(misaligned_count), 160'(mis_model));
`endif
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_ready = 1'b0;
    apply_line('0);

    lines[0]  = mk(4'b1010, 1'b0, 64'hDEAD_0000, 64'h1000, 64'hDEAD_0002, 64'h2008, 8'd3);
    lines[1]  = mk(4'b0000, 1'b1, 64'hBAD0, 64'hBAD1, 64'hBAD2, 64'hBAD3, 8'd1);
    lines[2]  = mk(4'b0000, 1'b0, 64'h11, 64'h22, 64'h33, 64'h44, 8'd0);
    lines[3]  = mk(4'b0000, 1'b0, 64'h55, 64'h66, 64'h77, 64'h88, 8'd0);
    lines[4]  = mk(4'b0000, 1'b0, 64'h99, 64'hAA, 64'hBB, 64'hCC, 8'd0);
    lines[5]  = mk(4'b0000, 1'b1, 64'hDD, 64'hEE, 64'hFF, 64'h00, 8'd0);
    lines[6]  = mk(4'b1111, 1'b1, 64'h10, 64'h20, 64'h30, 64'h40, 8'd3);
    lines[7]  = mk(4'b0001, 1'b0, 64'h1002, 64'hBAD, 64'hBAD, 64'hBAD, 8'd2);
    lines[8]  = mk(4'b1000, 1'b0, 64'hBAD, 64'hBAD, 64'hBAD, 64'h1004, 8'd2);
    lines[9]  = mk(4'b0110, 1'b0, 64'hBAD, 64'h3040, 64'h3001, 64'hBAD, 8'd6);
    lines[10] = mk(4'b1001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBAD, 64'hBAD, 64'h7, 8'd0);
    lines[11] = mk(4'b0000, 1'b1, '0, '0, '0, '0, 8'd0);

    //        first count stall rnd fetch reqs
    sc[0] = '{0, 2, 0, 1'b0, 2, 2};
    sc[1] = '{0, 2, 5, 1'b0, 2, 2};
    sc[2] = '{2, 4, 0, 1'b0, 4, 0};
    sc[3] = '{6, 1, 0, 1'b0, 1, 4};
    sc[4] = '{7, 4, 0, 1'b1, 4, 6};

    for (int i = 0; i < 5; i++) run_scen(sc[i]);

    // Reset asserted mid-DRAIN must clear everything at once.
    do_reset();
    setup('{6, 1, 1000, 1'b0, 1, 4});
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.req_valid) break;
    end
    repeat (2) step();
    chk("pre_reset_valid", 160'(bus.req_valid), 160'(1'b1));
    chk("pre_reset_addr", 160'(bus.req_address), 160'(64'h10));
    #2 reset = 1'b1;
    #1;
    chk_reset_vals();

    // A clean run afterwards proves nothing from the aborted line leaks through.
    run_scen(sc[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
